// File: rtl/rec_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rec_table_pkg
// Purpose  : Shared types, lookup table contents and FSM encoding for the
//            record table search block.
// Revision : 1.0 - initial release
// ============================================================================
package rec_table_pkg;

    typedef struct packed {
        logic [7:0] hex;
        logic [7:0] aval;
    } rec_t;

    localparam int         NUM_ENTRIES_C = 4;
    localparam logic [7:0] MISS_AVAL_C   = 8'h66;

    localparam rec_t c_rec_table [NUM_ENTRIES_C] = '{
        '{hex: 8'h14, aval: 8'haa},
        '{hex: 8'h24, aval: 8'hbb},
        '{hex: 8'h34, aval: 8'hcc},
        '{hex: 8'h56, aval: 8'hdd}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : rec_table_pkg
`default_nettype wire

// File: rtl/rec_table_rom.sv
`default_nettype none
// ============================================================================
// Module   : rec_table_rom
// Purpose  : Combinational index-to-record read of the constant lookup table.
// Revision : 1.0 - initial release
// ============================================================================
module rec_table_rom
    import rec_table_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_C
) (
    input  logic [1:0] addr,
    output rec_t       rd_rec
);

    // Addresses past the scanned range read as an all-zero record.
    always_comb begin
        rd_rec = '0;
        if (int'(addr) < NUM_ENTRIES) begin
            rd_rec = c_rec_table[addr];
        end
    end

endmodule : rec_table_rom
`default_nettype wire

// File: rtl/rec_table_search.sv
`default_nettype none
// ============================================================================
// Module   : rec_table_search
// Purpose  : Sequential key lookup over the record table, one entry per cycle,
//            with valid/ready request and response handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module rec_table_search
    import rec_table_pkg::*;
#(
    parameter logic [7:0] MISS_AVAL   = MISS_AVAL_C,
    parameter int         NUM_ENTRIES = NUM_ENTRIES_C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_key,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_hit,
    output logic [1:0] rsp_index,
    output logic [7:0] rsp_aval,
    output logic [7:0] rsp_tag
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_live;
    logic [7:0] r_key;
    logic [1:0] r_ptr;
    logic       r_hit;
    logic [1:0] r_index;
    logic [7:0] r_aval;
    logic [7:0] r_tag;
    rec_t       w_rec;
    logic       w_accept;
    logic       w_match;
    logic       w_last;
    logic       w_release;

    rec_table_rom #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_rom (
        .addr   (r_ptr),
        .rd_rec (w_rec)
    );

    assign w_accept  = (r_state == IDLE) && r_live && req_valid;
    assign w_match   = (r_state == SCAN) && (w_rec.hex == r_key);
    assign w_last    = (r_ptr == 2'(NUM_ENTRIES - 1));
    assign w_release = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SCAN;
            SCAN:    if (w_match || w_last) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response fields come straight from registers that are only non-zero in RESP.
    always_comb begin
        req_ready = (r_state == IDLE) && r_live;
        rsp_valid = (r_state == RESP);
        rsp_hit   = r_hit;
        rsp_index = r_index;
        rsp_aval  = r_aval;
        rsp_tag   = r_tag;
    end

    // r_live holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_key  <= 8'h00;
            r_ptr  <= 2'd0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_key <= req_key;
                r_ptr <= 2'd0;
            end else if ((r_state == SCAN) && !w_match && !w_last) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit   <= 1'b0;
            r_index <= 2'd0;
            r_aval  <= 8'h00;
            r_tag   <= 8'h00;
        end else if (w_match) begin
            r_hit   <= 1'b1;
            r_index <= r_ptr;
            r_aval  <= w_rec.aval;
            r_tag   <= 8'(r_ptr) * 8'h11;
        end else if ((r_state == SCAN) && w_last) begin
            r_hit   <= 1'b0;
            r_index <= 2'd0;
            r_aval  <= MISS_AVAL;
            r_tag   <= 8'h00;
        end else if (w_release) begin
            r_hit   <= 1'b0;
            r_index <= 2'd0;
            r_aval  <= 8'h00;
            r_tag   <= 8'h00;
        end
    end

endmodule : rec_table_search
`default_nettype wire

// File: tb/tb_rec_table_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_rec_table_search
// Purpose  : Directed self-checking bench for rec_table_search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rec_table_search;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_key;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [1:0] rsp_index;
    logic [7:0] rsp_aval;
    logic [7:0] rsp_tag;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    rec_table_search dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_index (rsp_index),
        .rsp_aval  (rsp_aval),
        .rsp_tag   (rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_hit"},   32'(rsp_hit),   32'd0);
        check({tag, "_rsp_index"}, 32'(rsp_index), 32'd0);
        check({tag, "_rsp_aval"},  32'(rsp_aval),  32'd0);
        check({tag, "_rsp_tag"},   32'(rsp_tag),   32'd0);
    endtask

    // Issue a request at a falling edge, then count rising edges until rsp_valid.
    task automatic issue_and_wait(input string tag, input logic [7:0] key, output int lat);
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_key   = key;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input int lat, input int exp_lat,
                             input logic hit, input logic [1:0] idx,
                             input logic [7:0] aval, input logic [7:0] rtag);
        check({tag, "_latency"},   32'(lat),       32'(exp_lat));
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_hit"},   32'(rsp_hit),   32'(hit));
        check({tag, "_rsp_index"}, 32'(rsp_index), 32'(idx));
        check({tag, "_rsp_aval"},  32'(rsp_aval),  32'(aval));
        check({tag, "_rsp_tag"},   32'(rsp_tag),   32'(rtag));
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_idle_outputs({tag, "_after"});
        check({tag, "_after_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_key   = 8'h00;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        // Hit at first entry, rsp_ready held high throughout
        rsp_ready = 1'b1;
        issue_and_wait("hit0", 8'h14, lat);
        check_rsp("hit0", lat, 1, 1'b1, 2'd0, 8'haa, 8'h00);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_idle_outputs("hit0_after");
        check("hit0_after_req_ready", 32'(req_ready), 32'd1);

        // Hit at last entry and middle entries
        issue_and_wait("hit3", 8'h56, lat);
        check_rsp("hit3", lat, 4, 1'b1, 2'd3, 8'hdd, 8'h33);
        release_rsp("hit3");

        issue_and_wait("hit1", 8'h24, lat);
        check_rsp("hit1", lat, 2, 1'b1, 2'd1, 8'hbb, 8'h11);
        release_rsp("hit1");

        issue_and_wait("hit2", 8'h34, lat);
        check_rsp("hit2", lat, 3, 1'b1, 2'd2, 8'hcc, 8'h22);
        release_rsp("hit2");

        // Miss
        issue_and_wait("miss", 8'h66, lat);
        check_rsp("miss", lat, 4, 1'b0, 2'd0, 8'h66, 8'h00);
        release_rsp("miss");

        // Backpressure with key change right after acceptance
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = 8'h34;
        @(negedge clk);
        req_valid = 1'b0;
        req_key   = 8'h14;
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check_rsp("bp", lat, 3, 1'b1, 2'd2, 8'hcc, 8'h22);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_index", 32'(rsp_index), 32'd2);
            check("bp_hold_aval",  32'(rsp_aval),  32'hcc);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        release_rsp("bp");

        // Reset mid-scan aborts the lookup
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = 8'h56;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_scan_req_ready", 32'(req_ready), 32'd0);
        check_idle_outputs("rst_scan");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_scan_no_rsp", 32'(seen), 32'd0);

        issue_and_wait("after_rst", 8'h24, lat);
        check_rsp("after_rst", lat, 2, 1'b1, 2'd1, 8'hbb, 8'h11);
        release_rsp("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_rec_table_search
`default_nettype wire
